midi_parser: RTL and testbench

MIDI_PARSER -- requirements
Module: midi_parser

---
 rtl/midi_parser.sv | 157 +++++++++++++++
 tb/tb_midi_parser.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: tracks running status, assembles voice messages and
// emits registered event ticks with held data for one selected channel.
module midi_parser #(
  parameter int unsigned CHANNEL = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [7:0]  din,
  output logic        note_on_tick,
  output logic        note_off_tick,
  output logic        cc_tick,
  output logic        bend_tick,
  output logic [6:0]  note,
  output logic [6:0]  velocity,
  output logic [6:0]  cc_num,
  output logic [6:0]  cc_val,
  output logic [13:0] bend
);

  localparam logic [3:0] CH = CHANNEL[3:0];

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, SYSEX} state_t;

  state_t      state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic [6:0]  d1_q, d1_d;
  logic        noteOn_q, noteOn_d;
  logic        noteOff_q, noteOff_d;
  logic        cc_q, cc_d;
  logic        bend_q, bend_d;
  logic [6:0]  note_q, note_d;
  logic [6:0]  vel_q, vel_d;
  logic [6:0]  ccNum_q, ccNum_d;
  logic [6:0]  ccVal_q, ccVal_d;
  logic [13:0] bendVal_q, bendVal_d;

  logic        msgDone;
  logic [6:0]  msgD1;
  logic [6:0]  msgD2;

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    d1_d      = d1_q;
    noteOn_d  = 1'b0;
    noteOff_d = 1'b0;
    cc_d      = 1'b0;
    bend_d    = 1'b0;
    note_d    = note_q;
    vel_d     = vel_q;
    ccNum_d   = ccNum_q;
    ccVal_d   = ccVal_q;
    bendVal_d = bendVal_q;
    msgDone   = 1'b0;
    msgD1     = d1_q;
    msgD2     = 7'd0;

    // Realtime bytes (F8-FF) fall through untouched so they can interleave anywhere.
    if (rx_done_tick && din < 8'hF8) begin
      if (din[7]) begin
        if (din < 8'hF0) begin
          status_d = din;
          state_d  = DATA1;
        end else begin
          status_d = 8'h00;
          state_d  = (din == 8'hF0) ? SYSEX : IDLE;
        end
      end else begin
        case (state_q)
          DATA1: begin
            d1_d = din[6:0];
            if (status_q[7:4] == 4'hC || status_q[7:4] == 4'hD) begin
              msgDone = 1'b1;
              msgD1   = din[6:0];
            end else begin
              state_d = DATA2;
            end
          end
          DATA2: begin
            msgDone = 1'b1;
            msgD2   = din[6:0];
            state_d = DATA1;
          end
          default: ;
        endcase
      end
    end

    if (msgDone && status_q[3:0] == CH) begin
      case (status_q[7:4])
        4'h8: begin
          noteOff_d = 1'b1;
          note_d    = msgD1;
          vel_d     = msgD2;
        end
        4'h9: begin
          noteOn_d  = (msgD2 != 7'd0);
          noteOff_d = (msgD2 == 7'd0);
          note_d    = msgD1;
          vel_d     = msgD2;
        end
        4'hB: begin
          cc_d    = 1'b1;
          ccNum_d = msgD1;
          ccVal_d = msgD2;
        end
        4'hE: begin
          bend_d    = 1'b1;
          bendVal_d = {msgD2, msgD1};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      status_q  <= 8'h00;
      d1_q      <= 7'd0;
      noteOn_q  <= 1'b0;
      noteOff_q <= 1'b0;
      cc_q      <= 1'b0;
      bend_q    <= 1'b0;
      note_q    <= 7'd0;
      vel_q     <= 7'd0;
      ccNum_q   <= 7'd0;
      ccVal_q   <= 7'd0;
      bendVal_q <= 14'h2000;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      d1_q      <= d1_d;
      noteOn_q  <= noteOn_d;
      noteOff_q <= noteOff_d;
      cc_q      <= cc_d;
      bend_q    <= bend_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
      ccNum_q   <= ccNum_d;
      ccVal_q   <= ccVal_d;
      bendVal_q <= bendVal_d;
    end
  end

  assign note_on_tick  = noteOn_q;
  assign note_off_tick = noteOff_q;
  assign cc_tick       = cc_q;
  assign bend_tick     = bend_q;
  assign note          = note_q;
  assign velocity      = vel_q;
  assign cc_num        = ccNum_q;
  assign cc_val        = ccVal_q;
  assign bend          = bendVal_q;

endmodule

// File: tb/tb_midi_parser.sv
// Scoreboard bench for midi_parser: a message-level model queues expected
// events, a negedge monitor pops them whenever a tick appears.
module tb_midi_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxDoneTick;
  logic [7:0]  din;
  logic        noteOnTick, noteOffTick, ccTick, bendTick;
  logic [6:0]  note, velocity, ccNum, ccVal;
  logic [13:0] bend;

  midi_parser #(.CHANNEL(0)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rxDoneTick), .din(din),
    .note_on_tick(noteOnTick), .note_off_tick(noteOffTick),
    .cc_tick(ccTick), .bend_tick(bendTick),
    .note(note), .velocity(velocity), .cc_num(ccNum), .cc_val(ccVal),
    .bend(bend)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int a; int b;} ev_t;
  ev_t expQ[$];

  int errors = 0;
  int checks = 0;
  bit monOn = 1'b0;

  int runStatus = 0;
  int dataBuf[$];

  logic [6:0]  hNote, hVel, hCcNum, hCcVal;
  logic [13:0] hBend;

  // Reference model: works on whole messages (running status + collected data bytes).
  task automatic modelByte(input int b);
    int need, hi, d1, d2;
    ev_t e;
    if (b >= 'hF8) return;
    if (b >= 'h80) begin
      runStatus = (b < 'hF0) ? b : 0;
      dataBuf.delete();
      return;
    end
    if (runStatus == 0) return;
    dataBuf.push_back(b);
    hi = runStatus / 16;
    need = (hi == 'hC || hi == 'hD) ? 1 : 2;
    if (dataBuf.size() < need) return;
    d1 = dataBuf[0];
    d2 = (need == 2) ? dataBuf[1] : 0;
    dataBuf.delete();
    if ((runStatus % 16) != 0) return;
    e.a = d1;
    e.b = d2;
    e.kind = 0;
    if (hi == 'h9) e.kind = (d2 != 0) ? 1 : 2;
    else if (hi == 'h8) e.kind = 2;
    else if (hi == 'hB) e.kind = 3;
    else if (hi == 'hE) begin
      e.kind = 4;
      e.a = d2 * 128 + d1;
    end
    if (e.kind != 0) expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int b);
    rxDoneTick = 1'b1;
    din = b[7:0];
    modelByte(b);
    @(posedge clk); #1;
    rxDoneTick = 1'b0;
    din = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sendList(input int bytes[$]);
    foreach (bytes[i]) applyStimulus(bytes[i]);
    idle(2);
  endtask

  task automatic checkOutput(input string name);
    @(negedge clk);
    checks++;
    if ({noteOnTick, noteOffTick, ccTick, bendTick} !== 4'b0 || note !== 7'd0 ||
        velocity !== 7'd0 || ccNum !== 7'd0 || ccVal !== 7'd0 || bend !== 14'h2000) begin
      errors++;
      $display("[TB] FAIL %s: got ticks=%b note=%h vel=%h ccNum=%h ccVal=%h bend=%h, expected all zero with bend=2000",
               name, {noteOnTick, noteOffTick, ccTick, bendTick}, note, velocity, ccNum, ccVal, bend);
    end
    @(posedge clk); #1;
  endtask

  // Reset, optionally with a simultaneous strobe that must be discarded.
  task automatic doReset(input bit withByte, input int b);
    reset = 1'b1;
    rxDoneTick = withByte;
    din = b[7:0];
    @(posedge clk); #1;
    reset = 1'b0;
    rxDoneTick = 1'b0;
    expQ.delete();
    dataBuf.delete();
    runStatus = 0;
    hNote = 7'd0; hVel = 7'd0; hCcNum = 7'd0; hCcVal = 7'd0; hBend = 14'h2000;
  endtask

  function automatic int randomByte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 45) return ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 127);
    if (r < 60) begin
      case ($urandom_range(0, 3))
        0: return 'h80;
        1: return 'h90;
        2: return 'hB0;
        default: return 'hE0;
      endcase
    end
    if (r < 70) return $urandom_range('h80, 'hEF);
    if (r < 78) return $urandom_range('hF8, 'hFF);
    if (r < 84) return 'hF0;
    if (r < 88) return $urandom_range('hF1, 'hF7);
    case ($urandom_range(0, 2))
      0: return 'hA0;
      1: return 'hC0;
      default: return 'hD0;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    int n, gk;
    ev_t e;
    if (monOn) begin
      n = int'(noteOnTick) + int'(noteOffTick) + int'(ccTick) + int'(bendTick);
      gk = noteOnTick ? 1 : noteOffTick ? 2 : ccTick ? 3 : bendTick ? 4 : 0;
      if (n > 1) begin
        checks++;
        errors++;
        $display("[TB] FAIL exclusiveTicks: got %0d ticks at once, expected at most 1", n);
      end
      if (n > 0) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpectedTick: got tick kind %0d, expected no event", gk);
        end else begin
          e = expQ.pop_front();
          if (gk != e.kind) begin
            errors++;
            $display("[TB] FAIL tickKind: got kind %0d, expected kind %0d", gk, e.kind);
          end else begin
            case (e.kind)
              1, 2: begin hNote = e.a[6:0]; hVel = e.b[6:0]; end
              3: begin hCcNum = e.a[6:0]; hCcVal = e.b[6:0]; end
              default: hBend = e.a[13:0];
            endcase
          end
        end
      end
      checks++;
      if (note !== hNote || velocity !== hVel || ccNum !== hCcNum || ccVal !== hCcVal || bend !== hBend) begin
        errors++;
        $display("[TB] FAIL heldData: got note=%h vel=%h ccNum=%h ccVal=%h bend=%h, expected note=%h vel=%h ccNum=%h ccVal=%h bend=%h",
                 note, velocity, ccNum, ccVal, bend, hNote, hVel, hCcNum, hCcVal, hBend);
      end
    end
  end

  initial begin
    reset = 1'b1;
    rxDoneTick = 1'b0;
    din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    doReset(1'b0, 0);
    monOn = 1'b1;
    checkOutput("resetState");

    sendList('{'h90, 'h3C, 'h64});
    sendList('{'h40, 'h00});
    sendList('{'hE0, 'hF8, 'h00, 'h40});
    sendList('{'hB0, 'h07, 'h7F});
    sendList('{'h91, 'h3C, 'h64});
    sendList('{'h90, 'h3C, 'hC0, 'h3C, 'h64});
    sendList('{'hF0, 'h01, 'h02, 'hF7, 'h3C});
    sendList('{'hE0, 'h7F, 'h7F, 'h00, 'h00});
    sendList('{'h80, 'h12, 'h34, 'h90, 'h55, 'hFA, 'h00});

    applyStimulus('h90);
    applyStimulus('h3C);
    doReset(1'b0, 0);
    applyStimulus('h64);
    idle(1);
    checkOutput("resetDropsPartial");

    applyStimulus('h90);
    applyStimulus('h3C);
    doReset(1'b1, 'h64);
    idle(1);
    checkOutput("resetBeatsStrobe");

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(randomByte());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drainQueue: got %0d events still pending, expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
